// File: rtl/comptest_emu_pkg.sv
// Shared types and constants for the comparator emulator.
package comptest_emu_pkg;

    localparam int ERR_MODE_W = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PULSE   = 3'd1,
        LATENCY = 3'd2,
        EMIT    = 3'd3,
        DEAD    = 3'd4
    } state_t;

    localparam logic [ERR_MODE_W-1:0] ERR_NONE        = 2'd0;
    localparam logic [ERR_MODE_W-1:0] ERR_WRONG_HS    = 2'd1;
    localparam logic [ERR_MODE_W-1:0] ERR_EXTRA_BIT   = 2'd2;
    localparam logic [ERR_MODE_W-1:0] ERR_INV_COMPOUT = 2'd3;

endpackage

// File: rtl/comparator_emulator_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    // Count up on inc, hold at all-ones, clear on reset or clr.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/comparator_emulator.sv
// Behavioural comparator/triad stand-in: answers an injector pulse window
// with a halfstrip hit word and compout level after a programmable latency.
module comparator_emulator
    import comptest_emu_pkg::*;
#(
    parameter int LAT_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pulse_en,
    input  logic                  compin,
    input  logic [4:0]            active_halfstrip,
    input  logic                  response_en,
    input  logic [LAT_W-1:0]      latency,
    input  logic [1:0]            hit_width,
    input  logic [LAT_W-1:0]      deadtime,
    input  logic [ERR_MODE_W-1:0] err_mode,
    input  logic                  cnt_rst,
    output logic [31:0]           halfstrips,
    output logic                  compout,
    output logic                  busy,
    output logic [CNT_W-1:0]      pulses_seen,
    output logic [CNT_W-1:0]      responses_sent,
    output logic                  overrun
);

    state_t                r_state;
    logic                  r_pulse_en_q;
    logic [4:0]            r_hs;
    logic [ERR_MODE_W-1:0] r_mode;
    logic                  r_resp_en;
    logic                  r_compin_seen;
    logic [LAT_W-1:0]      r_lat_cnt;
    logic [1:0]            r_emit_cnt;
    logic [LAT_W-1:0]      r_dead_cnt;
    logic [31:0]           r_halfstrips;
    logic                  r_compout;
    logic                  r_overrun;

    logic                  w_rise;
    logic                  w_accept;
    logic                  w_lat_done;
    logic                  w_emit_start;
    logic [4:0]            w_hs_next;
    logic [4:0]            w_hs_pair;
    logic [31:0]           w_pattern;
    logic                  w_compout;

    assign w_rise       = pulse_en & ~r_pulse_en_q;
    assign w_accept     = (r_state == IDLE) && w_rise;
    assign w_lat_done   = (r_state == LATENCY) && (r_lat_cnt == latency);
    assign w_emit_start = w_lat_done && r_resp_en;
    assign w_hs_next    = r_hs + 5'd1;
    assign w_hs_pair    = r_hs ^ 5'd1;

    // Hit word and compout level for the captured fault mode.
    always_comb begin
        w_pattern = 32'd0;
        w_compout = r_compin_seen;
        case (r_mode)
            ERR_NONE:        w_pattern = 32'd1 << r_hs;
            ERR_WRONG_HS:    w_pattern = 32'd1 << w_hs_next;
            ERR_EXTRA_BIT:   w_pattern = (32'd1 << r_hs) | (32'd1 << w_hs_pair);
            ERR_INV_COMPOUT: begin
                w_pattern = 32'd1 << r_hs;
                w_compout = ~r_compin_seen;
            end
            default:         w_pattern = 32'd1 << r_hs;
        endcase
    end

    // Registered copy of pulse_en for rising-edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pulse_en_q <= 1'b0;
        end else begin
            r_pulse_en_q <= pulse_en;
        end
    end

    // Response sequencer with registered hit outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_hs          <= 5'd0;
            r_mode        <= ERR_NONE;
            r_resp_en     <= 1'b0;
            r_compin_seen <= 1'b0;
            r_lat_cnt     <= '0;
            r_emit_cnt    <= 2'd0;
            r_dead_cnt    <= '0;
            r_halfstrips  <= 32'd0;
            r_compout     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state       <= PULSE;
                        r_hs          <= active_halfstrip;
                        r_mode        <= err_mode;
                        r_resp_en     <= response_en;
                        r_compin_seen <= 1'b0;
                    end
                end
                PULSE: begin
                    r_compin_seen <= r_compin_seen | compin;
                    if (!pulse_en) begin
                        r_state   <= LATENCY;
                        r_lat_cnt <= '0;
                    end
                end
                LATENCY: begin
                    if (w_lat_done) begin
                        r_dead_cnt <= '0;
                        if (r_resp_en) begin
                            r_state      <= EMIT;
                            r_emit_cnt   <= 2'd0;
                            r_halfstrips <= w_pattern;
                            r_compout    <= w_compout;
                        end else begin
                            r_state <= DEAD;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + {{(LAT_W-1){1'b0}}, 1'b1};
                    end
                end
                EMIT: begin
                    if (r_emit_cnt == hit_width) begin
                        r_state      <= DEAD;
                        r_dead_cnt   <= '0;
                        r_halfstrips <= 32'd0;
                        r_compout    <= 1'b0;
                    end else begin
                        r_emit_cnt <= r_emit_cnt + 2'd1;
                    end
                end
                DEAD: begin
                    if (r_dead_cnt == deadtime) begin
                        r_state <= IDLE;
                    end else begin
                        r_dead_cnt <= r_dead_cnt + {{(LAT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_halfstrips <= 32'd0;
                    r_compout    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flag for a pulse window that opened while a response was in flight.
    always_ff @(posedge clock) begin
        if (reset || cnt_rst) begin
            r_overrun <= 1'b0;
        end else if (w_rise && (r_state != IDLE)) begin
            r_overrun <= 1'b1;
        end else begin
            r_overrun <= r_overrun;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_pulses_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_rst),
        .inc   (w_accept),
        .count (pulses_seen)
    );

    sat_counter #(.CNT_W(CNT_W)) u_responses_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_rst),
        .inc   (w_emit_start),
        .count (responses_sent)
    );

    assign halfstrips = r_halfstrips;
    assign compout    = r_compout;
    assign busy       = (r_state != IDLE);
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_comparator_emulator.sv
// Directed bench for comparator_emulator; a 4-bit-counter copy checks saturation.
module tb_comparator_emulator;

    logic        clock = 1'b0;
    logic        reset;
    logic        pulse_en;
    logic        compin;
    logic [4:0]  active_halfstrip;
    logic        response_en;
    logic [3:0]  latency;
    logic [1:0]  hit_width;
    logic [3:0]  deadtime;
    logic [1:0]  err_mode;
    logic        cnt_rst;

    logic [31:0] halfstrips;
    logic        compout;
    logic        busy;
    logic [15:0] pulses_seen;
    logic [15:0] responses_sent;
    logic        overrun;

    logic [31:0] s_halfstrips;
    logic        s_compout;
    logic        s_busy;
    logic [3:0]  s_pulses_seen;
    logic [3:0]  s_responses_sent;
    logic        s_overrun;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    comparator_emulator #(.LAT_W(4), .CNT_W(16)) u_dut (
        .clock(clock), .reset(reset), .pulse_en(pulse_en), .compin(compin),
        .active_halfstrip(active_halfstrip), .response_en(response_en),
        .latency(latency), .hit_width(hit_width), .deadtime(deadtime),
        .err_mode(err_mode), .cnt_rst(cnt_rst), .halfstrips(halfstrips),
        .compout(compout), .busy(busy), .pulses_seen(pulses_seen),
        .responses_sent(responses_sent), .overrun(overrun)
    );

    comparator_emulator #(.LAT_W(4), .CNT_W(4)) u_dut_small (
        .clock(clock), .reset(reset), .pulse_en(pulse_en), .compin(compin),
        .active_halfstrip(active_halfstrip), .response_en(response_en),
        .latency(latency), .hit_width(hit_width), .deadtime(deadtime),
        .err_mode(err_mode), .cnt_rst(cnt_rst), .halfstrips(s_halfstrips),
        .compout(s_compout), .busy(s_busy), .pulses_seen(s_pulses_seen),
        .responses_sent(s_responses_sent), .overrun(s_overrun)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp_v);
        end
    endtask

    // Opens a pulse window of len cycles (compin high on its second cycle
    // when requested) and returns just after the edge that sees it fall.
    task automatic send_pulse(input int len, input bit with_compin);
        pulse_en = 1'b1;
        compin   = 1'b0;
        step();
        for (int i = 0; i < len - 1; i++) begin
            compin = with_compin && (i == 0);
            step();
        end
        compin   = 1'b0;
        pulse_en = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; pulse_en = 1'b0; compin = 1'b0; active_halfstrip = 5'd0;
        response_en = 1'b1; latency = 4'd0; hit_width = 2'd0; deadtime = 4'd0;
        err_mode = 2'd0; cnt_rst = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_hs", halfstrips, 32'h0);
        chk("rst_compout", 32'(compout), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_pulses", 32'(pulses_seen), 32'h0);
        chk("rst_resp", 32'(responses_sent), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);

        // Basic hit: latency 3, single-cycle hit at F+4, deadtime 2.
        latency = 4'd3; hit_width = 2'd0; deadtime = 4'd2; active_halfstrip = 5'd5;
        send_pulse(4, 1'b1);
        chk("basic_busy_f", 32'(busy), 32'h1);
        chk("basic_hs_f", halfstrips, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("basic_hs_lat", halfstrips, 32'h0);
        end
        step();
        chk("basic_hs", halfstrips, 32'h0000_0020);
        chk("basic_compout", 32'(compout), 32'h1);
        chk("basic_pulses", 32'(pulses_seen), 32'h1);
        chk("basic_resp", 32'(responses_sent), 32'h1);
        step();
        chk("basic_hs_end", halfstrips, 32'h0);
        chk("basic_compout_end", 32'(compout), 32'h0);
        step(); step();
        chk("basic_busy_dead", 32'(busy), 32'h1);
        step();
        chk("basic_busy_idle", 32'(busy), 32'h0);

        // Wrong halfstrip wraps 31 -> 0, held for four cycles.
        latency = 4'd0; hit_width = 2'd3; deadtime = 4'd0;
        active_halfstrip = 5'd31; err_mode = 2'd1;
        send_pulse(2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wrap_hs", halfstrips, 32'h0000_0001);
            chk("wrap_compout", 32'(compout), 32'h1);
        end
        step();
        chk("wrap_hs_end", halfstrips, 32'h0);
        step();
        chk("wrap_busy", 32'(busy), 32'h0);
        chk("wrap_resp", 32'(responses_sent), 32'h2);

        // Extra same-strip bit; later input changes must not disturb it.
        hit_width = 2'd0; active_halfstrip = 5'd4; err_mode = 2'd2;
        send_pulse(2, 1'b0);
        active_halfstrip = 5'd9; err_mode = 2'd0;
        step();
        chk("extra_hs", halfstrips, 32'h0000_0030);
        chk("extra_compout", 32'(compout), 32'h0);
        step(); step();
        chk("extra_busy", 32'(busy), 32'h0);

        // Inverted compout with no compin seen.
        active_halfstrip = 5'd7; err_mode = 2'd3;
        send_pulse(2, 1'b0);
        step();
        chk("inv_hs", halfstrips, 32'h0000_0080);
        chk("inv_compout", 32'(compout), 32'h1);
        step(); step();
        chk("inv_pulses", 32'(pulses_seen), 32'h4);
        chk("inv_resp", 32'(responses_sent), 32'h4);

        // No response: captured response_en = 0.
        err_mode = 2'd0; active_halfstrip = 5'd1; latency = 4'd2; deadtime = 4'd1;
        response_en = 1'b0;
        send_pulse(2, 1'b1);
        response_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("noresp_hs", halfstrips, 32'h0);
            step();
        end
        chk("noresp_busy", 32'(busy), 32'h0);
        chk("noresp_pulses", 32'(pulses_seen), 32'h5);
        chk("noresp_resp", 32'(responses_sent), 32'h4);

        // Overrun during LATENCY, then cnt_rst while the hit is still pending.
        latency = 4'd3; hit_width = 2'd1; deadtime = 4'd0; active_halfstrip = 5'd2;
        send_pulse(2, 1'b0);
        step();
        pulse_en = 1'b1;
        step();
        chk("ovr_flag", 32'(overrun), 32'h1);
        chk("ovr_pulses", 32'(pulses_seen), 32'h6);
        pulse_en = 1'b0; cnt_rst = 1'b1;
        step();
        cnt_rst = 1'b0;
        chk("ovr_clr_pulses", 32'(pulses_seen), 32'h0);
        chk("ovr_clr_resp", 32'(responses_sent), 32'h0);
        chk("ovr_clr_flag", 32'(overrun), 32'h0);
        chk("ovr_clr_busy", 32'(busy), 32'h1);
        step();
        chk("ovr_hs", halfstrips, 32'h0000_0004);
        chk("ovr_resp", 32'(responses_sent), 32'h1);
        step();
        chk("ovr_hs2", halfstrips, 32'h0000_0004);
        step();
        chk("ovr_hs_end", halfstrips, 32'h0);
        step();
        chk("ovr_busy", 32'(busy), 32'h0);

        // cnt_rst beats an accept on the same edge.
        latency = 4'd0; response_en = 1'b0;
        pulse_en = 1'b1; cnt_rst = 1'b1;
        step();
        cnt_rst = 1'b0;
        chk("clrpri_pulses", 32'(pulses_seen), 32'h0);
        chk("clrpri_busy", 32'(busy), 32'h1);
        pulse_en = 1'b0;
        step(); step(); step();
        chk("clrpri_idle", 32'(busy), 32'h0);
        chk("clrpri_resp", 32'(responses_sent), 32'h0);

        // Reset in the middle of EMIT.
        response_en = 1'b1; hit_width = 2'd3; active_halfstrip = 5'd10;
        send_pulse(2, 1'b1);
        step();
        chk("rstmid_hs_pre", halfstrips, 32'h0000_0400);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstmid_hs", halfstrips, 32'h0);
        chk("rstmid_busy", 32'(busy), 32'h0);
        chk("rstmid_compout", 32'(compout), 32'h0);
        latency = 4'd1; hit_width = 2'd0;
        send_pulse(2, 1'b1);
        step();
        chk("after_rst_hs_lat", halfstrips, 32'h0);
        step();
        chk("after_rst_hs", halfstrips, 32'h0000_0400);
        chk("after_rst_compout", 32'(compout), 32'h1);
        chk("after_rst_resp", 32'(responses_sent), 32'h1);
        step(); step();
        chk("after_rst_busy", 32'(busy), 32'h0);

        // Rise on the same edge DEAD returns to IDLE is ignored.
        latency = 4'd0; deadtime = 4'd0; response_en = 1'b0;
        pulse_en = 1'b1; step();
        pulse_en = 1'b0; step(); step();
        pulse_en = 1'b1; step();
        chk("deadedge_overrun", 32'(overrun), 32'h1);
        chk("deadedge_pulses", 32'(pulses_seen), 32'h2);
        chk("deadedge_busy", 32'(busy), 32'h0);
        pulse_en = 1'b0; step();

        // Saturation on the 4-bit copy; the 16-bit counter keeps counting.
        cnt_rst = 1'b1; step(); cnt_rst = 1'b0;
        chk("sat_clr", 32'(s_pulses_seen), 32'h0);
        for (int i = 0; i < 15; i++) begin
            pulse_en = 1'b1; step();
            pulse_en = 1'b0; step(); step(); step();
        end
        chk("sat_small_15", 32'(s_pulses_seen), 32'hF);
        chk("sat_big_15", 32'(pulses_seen), 32'd15);
        for (int i = 0; i < 5; i++) begin
            pulse_en = 1'b1; step();
            pulse_en = 1'b0; step(); step(); step();
        end
        chk("sat_small_hold", 32'(s_pulses_seen), 32'hF);
        chk("sat_big_20", 32'(pulses_seen), 32'd20);
        chk("sat_small_resp", 32'(s_responses_sent), 32'h0);
        chk("sat_small_hs", s_halfstrips, 32'h0);
        chk("sat_small_compout", 32'(s_compout), 32'h0);
        chk("sat_small_busy", 32'(s_busy), 32'h0);
        chk("sat_small_overrun", 32'(s_overrun), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comparator_emulator.md
Name: comparator_emulator

Overview:
- Behavioural stand-in for the comparator ASIC and triad path.
- Responds to the injector's pulse window (pulse_en, compin) with a 32-bit halfstrip hit word and a compout level after a programmable latency.
- Lets the injector, its error counters and its timeout logic run in firmware loopback with no front-end hardware attached.
- Deliberate fault modes exercise each injector error counter independently.

Parameters:
- LAT_W, 4, width of latency and deadtime fields
- CNT_W, 16, width of the statistics counters

Ports:
- clock  in  1  fabric clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- pulse_en  in  1  injector pulse window
- compin  in  1  injector comparator-input pulse
- active_halfstrip  in  5  halfstrip to report as hit
- response_en  in  1  0 = never respond, which forces an injector timeout
- latency  in  LAT_W  extra cycles between the pulse falling edge and the hit
- hit_width  in  2  hit held for hit_width+1 cycles
- deadtime  in  LAT_W  quiet cycles after the hit before re-arming
- err_mode  in  2  fault injection: 0 none, 1 wrong halfstrip, 2 extra same-strip bit, 3 inverted compout
- cnt_rst  in  1  clears counters and overrun
- halfstrips  out  32  emulated hit word, zero outside EMIT
- compout  out  1  emulated comparator output, zero outside EMIT
- busy  out  1  state != IDLE
- pulses_seen  out  CNT_W  pulse windows accepted
- responses_sent  out  CNT_W  hit words emitted
- overrun  out  1  sticky: pulse_en rose while not IDLE

Behaviour:
- Reset values:
  - state = IDLE
  - halfstrips, compout, counters, overrun = 0
  - busy = 0 in the cycle after reset is sampled
  - internal pulse_en_q = 0
- Reset mid-operation: the response is abandoned and outputs are zero the next cycle.
- Rising edge detect: rise = pulse_en & ~pulse_en_q, where pulse_en_q is registered.

State machine:
- IDLE:
  - on rise -> PULSE
  - capture active_halfstrip, err_mode and response_en into hold registers; later input changes do not affect this response
  - clear compin_seen
  - increment pulses_seen
- PULSE:
  - each cycle, compin_seen |= compin
  - first cycle pulse_en is sampled 0 (edge F) -> LATENCY with lat_cnt = 0
- LATENCY:
  - if lat_cnt == latency: -> EMIT when captured response_en = 1, otherwise -> DEAD
  - else lat_cnt++
  - LATENCY therefore lasts latency+1 cycles; the first nonzero halfstrips cycle starts at edge F+latency+1
- EMIT:
  - lasts exactly hit_width+1 cycles, then -> DEAD with dead_cnt = 0
  - responses_sent increments once, on entry
- DEAD:
  - if dead_cnt == deadtime -> IDLE, else dead_cnt++
  - lasts deadtime+1 cycles
- A pulse window held high indefinitely stays in PULSE; there is no timeout here, the injector owns timeouts.

Outputs:
- halfstrips and compout are registers, loaded on the edge entering EMIT and cleared on the edge leaving it. They are nonzero only while state == EMIT.
- Pattern by captured mode, with h = captured halfstrip:
  - mode 0: 1<<h
  - mode 1: 1<<((h+1) mod 32), 5-bit wrap, so h = 31 gives bit 0
  - mode 2: (1<<h) | (1<<(h^1)), same strip; offsets fail, thresholds pass
  - mode 3: 1<<h
- compout = compin_seen, inverted in mode 3.

Event rules:
- rise while not IDLE: ignored, no count, overrun set.
- rise on the same edge that DEAD returns to IDLE: ignored, because state was not IDLE at that edge.
- Counters saturate at all-ones.
- cnt_rst has priority over a same-cycle increment and does not disturb state.

Decomposition:
- Shared package comptest_emu_pkg:
  - state encoding: IDLE, PULSE, LATENCY, EMIT, DEAD
  - ERR_NONE, ERR_WRONG_HS, ERR_EXTRA_BIT, ERR_INV_COMPOUT
  - ERR_MODE_W = 2
- One sub-module, sat_counter: CNT_W-bit saturating counter with synchronous clear; instantiated twice.
- Pattern generation stays inline.

Test Plan:
- Basic hit: latency=3, hit_width=0, err_mode=0, h=5, 4-cycle pulse_en, compin high 1 cycle. Required: halfstrips = 0x00000020 and compout = 1 for exactly 1 cycle starting at edge F+4; pulses_seen = responses_sent = 1; busy back to 0 after deadtime+1 cycles.
- Wrap and width: h=31, err_mode=1, hit_width=3. Required: halfstrips = 0x00000001 for 4 cycles. With err_mode=2, h=4: halfstrips = 0x00000030.
- No response: response_en=0. Required: halfstrips stays 0 throughout; pulses_seen increments; responses_sent does not; state returns to IDLE.
- Overrun: second pulse_en rise during LATENCY or EMIT. Required: ignored; overrun = 1; pulses_seen = 1. Then cnt_rst pulse: counters = 0, overrun = 0, the in-flight hit still emitted.
- Reset mid-EMIT: reset asserted during EMIT. Required: halfstrips = 0, busy = 0 next cycle; a later pulse produces a normal response.
- Saturation: force pulses_seen near 0xFFFF (run 65536+ pulses, latency=0, deadtime=0). Required: holds at 0xFFFF, no wrap to 0.
